digi_ota_array: RTL
===================

DIGI_OTA_ARRAY -- requirements
Module: digi_ota_array

Interface
REQ-001 SHALL provide parameter CH, default 4, number of independent comparator/driver channels (legal 1..8).
REQ-002 SHALL provide parameter HYST, default 3, consecutive agreeing cycles required before a drive change (legal 1..15).
REQ-003 SHALL provide parameter DEAD, default 2, Hi-Z cycles inserted on a HI<->LO reversal (legal 1..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  global enable; 0 forces all channels to Hi-Z.
REQ-007 SHALL have port mode_hold  input  1  1 = tie input holds last drive; 0 = tie releases to Hi-Z.
REQ-008 SHALL have port vip  input  CH  per-channel non-inverting input, asynchronous to clk.
REQ-009 SHALL have port vin  input  CH  per-channel inverting input, asynchronous to clk.
REQ-010 SHALL have port out  output  CH  per-channel drive value.
REQ-011 SHALL have port out_oe  output  CH  per-channel drive enable, 1 = driving, 0 = Hi-Z.
REQ-012 SHALL have port switch_cnt  output  16  count of channel entries into HI or LO, saturating.

Function
REQ-013 SHALL pass vip and vin of every channel through a two-flop synchroniser; decisions use synchronised values only.
REQ-014 SHALL classify each channel every cycle: UP (p=1,n=0), DN (p=0,n=1), TIE (p==n).
REQ-015 SHALL implement per-channel FSM states Z, HI, LO, DEAD; out_oe=1 only in HI/LO; out=1 only in HI, else 0.
REQ-016 SHALL form a request per channel: Z: UP->HI, DN->LO; HI: DN->LO, TIE with mode_hold=0->Z; LO: UP->HI, TIE with mode_hold=0->Z; any other case = no request.
REQ-017 SHALL keep a per-channel hysteresis counter that increments while the same request persists and clears when the request disappears or changes.
REQ-018 SHALL take a requested transition on the edge completing the HYST-th consecutive cycle of that request, then clear the counter; HYST=1 acts on the first cycle.
REQ-019 SHALL enter HI or LO directly from Z; a HI->LO or LO->HI request SHALL enter DEAD instead, latching the target.
REQ-020 SHALL hold DEAD for exactly DEAD cycles, then enter the latched target unconditionally; input activity during DEAD SHALL be ignored and the counter held at 0.
REQ-021 SHALL produce a drive change HYST+2 rising edges after the input change is first sampled (Z->HI/LO, HI/LO->Z), plus DEAD cycles for reversals.
REQ-022 SHALL, when en=0, move every channel to Z on the next edge and clear all hysteresis/DEAD counters; synchronisers keep running; transitions resume normally when en returns to 1.
REQ-023 SHALL increment switch_cnt by the number of channels entering HI or LO on a given edge (0..CH), saturating at 0xFFFF with no wrap.
REQ-024 SHALL treat channels fully independently; simultaneous events on several channels all take effect on the same edge.

Reset
REQ-025 SHALL, while rst=1, asynchronously force all FSMs to Z, out=0, out_oe=0, all counters and synchroniser flops to 0, switch_cnt=0.
REQ-026 SHALL, on rst deassertion mid-operation, start from Z with no stale DEAD target or hysteresis count.

Verification
REQ-027 Reset: rst=1 with random inputs -> out=0, out_oe=0, switch_cnt=0 immediately, without a clock edge.
REQ-028 Drive: defaults, en=1, ch0 vip=1 vin=0 from Z -> out_oe[0]=1, out[0]=1 exactly 5 edges after first sample; switch_cnt=1.
REQ-029 Reversal: then ch0 vip=0 vin=1 -> DEAD after 5 edges, out_oe[0]=0 for 2 cycles, then out[0]=0, out_oe[0]=1; switch_cnt=2.
REQ-030 Glitch reject: ch0 in HI, DN for 2 synchronised cycles then UP -> no change on out/out_oe, switch_cnt unchanged.
REQ-031 Tie: ch1 in LO, vip=vin=1 with mode_hold=0 -> Z after 5 edges; repeat with mode_hold=1 -> LO held indefinitely.
REQ-032 Abort/saturation: en=0 during DEAD -> Z next edge, no later drive; all 4 channels UP together -> switch_cnt +4 on one edge; preload near 0xFFFF -> holds at 0xFFFF.

Source files
------------

// File: rtl/digi_ota_array.sv
// digi_ota_array: array of synchronised digital comparators, each driving a
// tri-stateable output through a hysteresis filter and a dead-time interlock.
module digi_ota_array #(
    parameter int unsigned CH   = 4,
    parameter int unsigned HYST = 3,
    parameter int unsigned DEAD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode_hold,
    input  logic [CH-1:0] vip,
    input  logic [CH-1:0] vin,
    output logic [CH-1:0] out,
    output logic [CH-1:0] out_oe,
    output logic [15:0]   switch_cnt
);

    localparam int unsigned CW = 4;
    localparam int unsigned EW = 4;

    typedef enum logic [1:0] {ST_Z, ST_HI, ST_LO, ST_DEAD} state_e;
    typedef enum logic [1:0] {RQ_NONE, RQ_HI, RQ_LO, RQ_Z} req_e;

    logic [CH-1:0] vip_s1_q, vip_s2_q, vin_s1_q, vin_s2_q;
    state_e        state_q [CH];
    state_e        state_d [CH];
    state_e        tgt_q   [CH];
    state_e        tgt_d   [CH];
    req_e          req_q   [CH];
    req_e          req_d   [CH];
    logic [CW-1:0] hcnt_q  [CH];
    logic [CW-1:0] hcnt_d  [CH];
    logic [CW-1:0] dcnt_q  [CH];
    logic [CW-1:0] dcnt_d  [CH];
    logic [CH-1:0] out_q, out_d, oe_q, oe_d;
    logic [15:0]   switch_cnt_q, switch_cnt_d;

    // Two-flop synchronisers for the asynchronous comparator inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vip_s1_q <= '0;
            vip_s2_q <= '0;
            vin_s1_q <= '0;
            vin_s2_q <= '0;
        end else begin
            vip_s1_q <= vip;
            vip_s2_q <= vip_s1_q;
            vin_s1_q <= vin;
            vin_s2_q <= vin_s1_q;
        end
    end

    // Per-channel request, hysteresis filter, dead-time and switch counting
    always_comb begin
        logic [EW-1:0] entries;
        logic [16:0]   sum;
        req_e          req;
        logic [CW-1:0] run;
        logic          up, dn, tie;

        entries = '0;
        sum     = '0;
        req     = RQ_NONE;
        run     = '0;
        up      = 1'b0;
        dn      = 1'b0;
        tie     = 1'b0;
        out_d   = '0;
        oe_d    = '0;

        for (int c = 0; c < int'(CH); c++) begin
            state_d[c] = state_q[c];
            tgt_d[c]   = tgt_q[c];
            req_d[c]   = req_q[c];
            hcnt_d[c]  = hcnt_q[c];
            dcnt_d[c]  = dcnt_q[c];

            up  = vip_s2_q[c] & ~vin_s2_q[c];
            dn  = ~vip_s2_q[c] & vin_s2_q[c];
            tie = (vip_s2_q[c] == vin_s2_q[c]);
            run = '0;

            req = RQ_NONE;
            case (state_q[c])
                ST_Z: begin
                    if (up)      req = RQ_HI;
                    else if (dn) req = RQ_LO;
                end
                ST_HI: begin
                    if (dn)                    req = RQ_LO;
                    else if (tie && !mode_hold) req = RQ_Z;
                end
                ST_LO: begin
                    if (up)                    req = RQ_HI;
                    else if (tie && !mode_hold) req = RQ_Z;
                end
                default: req = RQ_NONE;
            endcase

            if (!en) begin
                state_d[c] = ST_Z;
                tgt_d[c]   = ST_Z;
                req_d[c]   = RQ_NONE;
                hcnt_d[c]  = '0;
                dcnt_d[c]  = '0;
            end else if (state_q[c] == ST_DEAD) begin
                // Inputs are ignored while the output is parked in Hi-Z
                req_d[c]  = RQ_NONE;
                hcnt_d[c] = '0;
                if (dcnt_q[c] == CW'(DEAD - 1)) begin
                    state_d[c] = tgt_q[c];
                    dcnt_d[c]  = '0;
                end else begin
                    dcnt_d[c] = dcnt_q[c] + CW'(1);
                end
            end else if (req == RQ_NONE) begin
                req_d[c]  = RQ_NONE;
                hcnt_d[c] = '0;
            end else begin
                // A changed request restarts the run at its first cycle
                run = (req == req_q[c]) ? hcnt_q[c] : '0;
                if (run == CW'(HYST - 1)) begin
                    hcnt_d[c] = '0;
                    req_d[c]  = RQ_NONE;
                    case (req)
                        RQ_HI: begin
                            if (state_q[c] == ST_LO) begin
                                state_d[c] = ST_DEAD;
                                tgt_d[c]   = ST_HI;
                                dcnt_d[c]  = '0;
                            end else begin
                                state_d[c] = ST_HI;
                            end
                        end
                        RQ_LO: begin
                            if (state_q[c] == ST_HI) begin
                                state_d[c] = ST_DEAD;
                                tgt_d[c]   = ST_LO;
                                dcnt_d[c]  = '0;
                            end else begin
                                state_d[c] = ST_LO;
                            end
                        end
                        default: state_d[c] = ST_Z;
                    endcase
                end else begin
                    hcnt_d[c] = run + CW'(1);
                    req_d[c]  = req;
                end
            end

            if ((state_d[c] == ST_HI || state_d[c] == ST_LO) && state_d[c] != state_q[c])
                entries = entries + EW'(1);

            out_d[c] = (state_d[c] == ST_HI);
            oe_d[c]  = (state_d[c] == ST_HI) || (state_d[c] == ST_LO);
        end

        sum          = 17'(switch_cnt_q) + 17'(entries);
        switch_cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Channel state, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < int'(CH); c++) begin
                state_q[c] <= ST_Z;
                tgt_q[c]   <= ST_Z;
                req_q[c]   <= RQ_NONE;
                hcnt_q[c]  <= '0;
                dcnt_q[c]  <= '0;
            end
            out_q        <= '0;
            oe_q         <= '0;
            switch_cnt_q <= '0;
        end else begin
            for (int c = 0; c < int'(CH); c++) begin
                state_q[c] <= state_d[c];
                tgt_q[c]   <= tgt_d[c];
                req_q[c]   <= req_d[c];
                hcnt_q[c]  <= hcnt_d[c];
                dcnt_q[c]  <= dcnt_d[c];
            end
            out_q        <= out_d;
            oe_q         <= oe_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign out        = out_q;
    assign out_oe     = oe_q;
    assign switch_cnt = switch_cnt_q;

endmodule
